// File: rtl/tsc_mem_pkg.sv
// Shared encodings for the TSC memory responder: FSM states, port select, op type and default widths.
package tsc_mem_pkg;

    localparam int TSC_WORD_W = 16;
    localparam int TSC_ADDR_W = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/mem_responder_if.sv
// Fetch and data request/response bundle between the CPU pipeline (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
);
    logic              i_req_read;
    logic [ADDR_W-1:0] i_addr;
    logic [WORD_W-1:0] i_data;
    logic              i_ready;
    logic              d_req_read;
    logic              d_req_write;
    logic [ADDR_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic [WORD_W-1:0] d_rdata;
    logic              d_ready;
    logic              busy;

    modport master (
        output i_req_read, i_addr, d_req_read, d_req_write, d_addr, d_wdata,
        input  i_data, i_ready, d_rdata, d_ready, busy
    );

    modport slave (
        input  i_req_read, i_addr, d_req_read, d_req_write, d_addr, d_wdata,
        output i_data, i_ready, d_rdata, d_ready, busy
    );
endinterface

// File: rtl/mem_storage.sv
// Word array with synchronous write and combinational read; contents survive reset.
module mem_storage #(
    parameter int WORD_W     = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [WORD_W-1:0]     wdata_i,
    output logic [WORD_W-1:0]     rdata_o
);
    logic [WORD_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: alternating arbiter between fetch and data ports, one access in flight,
// ready pulses for one cycle LATENCY cycles after acceptance; requests are ignored while busy.
module mem_responder
    import tsc_mem_pkg::*;
#(
    parameter int WORD_W     = TSC_WORD_W,
    parameter int ADDR_W     = TSC_ADDR_W,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    port_e                 port_q, port_d;
    port_e                 last_q, last_d;
    op_e                   op_q, op_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [WORD_W-1:0]     i_data_q, i_data_d;
    logic [WORD_W-1:0]     d_rdata_q, d_rdata_d;
    logic [WORD_W-1:0]     rd_word;
    logic                  mem_we;
    logic                  d_req;
    logic                  unused_hi_addr;

    assign d_req          = bus.d_req_read | bus.d_req_write;
    assign unused_hi_addr = ^{bus.i_addr[ADDR_W-1:DEPTH_LOG2], bus.d_addr[ADDR_W-1:DEPTH_LOG2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            port_q    <= PORT_INSTR;
            last_q    <= PORT_INSTR;
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_q    <= port_d;
            last_q    <= last_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        last_d    = last_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;
        mem_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req_read || d_req) begin
                    // Data wins when alone or when fetch was the last port served.
                    if (d_req && (!bus.i_req_read || last_q == PORT_INSTR)) begin
                        port_d  = PORT_DATA;
                        op_d    = bus.d_req_write ? OP_WRITE : OP_READ;
                        addr_d  = bus.d_addr[DEPTH_LOG2-1:0];
                        wdata_d = bus.d_wdata;
                    end else begin
                        port_d  = PORT_INSTR;
                        op_d    = OP_READ;
                        addr_d  = bus.i_addr[DEPTH_LOG2-1:0];
                    end
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = port_q;
                if (port_q == PORT_INSTR) begin
                    i_data_d = rd_word;
                end else if (op_q == OP_WRITE) begin
                    mem_we = 1'b1;
                end else begin
                    d_rdata_d = rd_word;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mem_storage #(
        .WORD_W     (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_storage (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (rd_word)
    );

    // Response words appear combinationally during RESP and are held in the _q copies afterwards.
    assign bus.i_ready = (state_q == RESP) && (port_q == PORT_INSTR);
    assign bus.d_ready = (state_q == RESP) && (port_q == PORT_DATA);
    assign bus.i_data  = bus.i_ready ? rd_word : i_data_q;
    assign bus.d_rdata = (bus.d_ready && op_q == OP_READ) ? rd_word : d_rdata_q;
    assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a transaction-level model (word array, last-served port, held responses).
module tb_mem_responder;
    import tsc_mem_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if #(.WORD_W(16), .ADDR_W(16)) bus  ();
    mem_responder_if #(.WORD_W(16), .ADDR_W(16)) bus1 ();

    mem_responder #(.WORD_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(LAT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_responder #(.WORD_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(1)) u_l1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [256];
    int          last_port;
    logic [15:0] exp_i;
    logic [15:0] exp_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        last_port = 0;
        exp_i     = 16'h0;
        exp_d     = 16'h0;
    endtask

    task automatic drop_reqs();
        bus.i_req_read  = 1'b0;
        bus.d_req_read  = 1'b0;
        bus.d_req_write = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_i_ready"}, bus.i_ready, 0);
        chk({tag, "_d_ready"}, bus.d_ready, 0);
        chk({tag, "_i_data"},  bus.i_data, 0);
        chk({tag, "_d_rdata"}, bus.d_rdata, 0);
        chk({tag, "_busy"},    bus.busy, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic txn(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] wd);
        bit want_d;
        bit got;
        int n;
        want_d = (dr || dw) && (!ir || last_port == 0);
        bus.i_req_read  = ir;
        bus.i_addr      = ia;
        bus.d_req_read  = dr;
        bus.d_req_write = dw;
        bus.d_addr      = da;
        bus.d_wdata     = wd;
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            chk("busy_active", bus.busy, 1);
            chk("ready_excl", bus.i_ready & bus.d_ready, 0);
            if (bus.i_ready || bus.d_ready) got = 1'b1;
        end
        chk("timeout", got, 1);
        chk("latency", n, LAT);
        chk("port", bus.d_ready, want_d);
        if (want_d) begin
            last_port = 1;
            if (dw) begin
                ref_mem[da[7:0]] = wd;
            end else begin
                exp_d = ref_mem[da[7:0]];
            end
            chk("d_rdata", bus.d_rdata, exp_d);
        end else begin
            last_port = 0;
            exp_i = ref_mem[ia[7:0]];
            chk("i_data", bus.i_data, exp_i);
            chk("d_rdata_hold", bus.d_rdata, exp_d);
        end
        drop_reqs();
        @(negedge clk);
        chk("ready_single", bus.i_ready | bus.d_ready, 0);
        chk("busy_idle", bus.busy, 0);
        chk("i_data_hold", bus.i_data, exp_i);
    endtask

    task automatic l1_req(input logic ir, input logic dw, input logic dr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp);
        bit got;
        int n;
        int nb;
        bus1.i_req_read  = ir;
        bus1.i_addr      = addr;
        bus1.d_req_write = dw;
        bus1.d_req_read  = dr;
        bus1.d_addr      = addr;
        bus1.d_wdata     = wd;
        got = 1'b0;
        n   = 0;
        nb  = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus1.busy) nb++;
            if (bus1.i_ready || bus1.d_ready) got = 1'b1;
        end
        chk("l1_timeout", got, 1);
        chk("l1_latency", n, 1);
        chk("l1_busy_cycles", nb, 1);
        if (ir)      chk("l1_i_data", bus1.i_data, exp);
        else if (dr) chk("l1_d_rdata", bus1.d_rdata, exp);
        bus1.i_req_read  = 1'b0;
        bus1.d_req_write = 1'b0;
        bus1.d_req_read  = 1'b0;
        @(negedge clk);
        chk("l1_busy_idle", bus1.busy, 0);
    endtask

    initial begin
        logic ir, dr, dw;
        reset = 1'b1;
        drop_reqs();
        bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus1.i_req_read = 1'b0; bus1.d_req_read = 1'b0; bus1.d_req_write = 1'b0;
        bus1.i_addr = '0; bus1.d_addr = '0; bus1.d_wdata = '0;
        model_reset();
        #1;
        check_idle_outputs("rst");
        @(negedge clk);
        reset = 1'b0;

        // Write then read back, plus preload for the tie test.
        txn(0, 16'h0, 0, 1, 16'h0010, 16'hBEEF);
        txn(0, 16'h0, 1, 0, 16'h0010, 16'h0);
        txn(0, 16'h0, 0, 1, 16'h0020, 16'h5A5A);

        // Reset restores the tie priority but keeps storage.
        reset = 1'b1;
        #1;
        check_idle_outputs("rst2");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) txn(1, 16'h0010, 1, 0, 16'h0020, 16'h0);

        // Address wrap.
        txn(0, 16'h0, 0, 1, 16'h0105, 16'h1234);
        txn(0, 16'h0, 1, 0, 16'h0005, 16'h0);

        // Read and write together: the write wins.
        txn(0, 16'h0, 0, 1, 16'h0040, 16'h0055);
        txn(0, 16'h0, 1, 1, 16'h0040, 16'h00AA);
        txn(0, 16'h0, 1, 0, 16'h0040, 16'h0);

        // Reset during WAIT of a write aborts it.
        txn(0, 16'h0, 0, 1, 16'h0030, 16'h0000);
        bus.d_req_write = 1'b1; bus.d_addr = 16'h0030; bus.d_wdata = 16'hFFFF;
        @(negedge clk);
        chk("wait_busy", bus.busy, 1);
        chk("wait_no_ready", bus.d_ready, 0);
        reset = 1'b1;
        drop_reqs();
        #1;
        check_idle_outputs("rst_mid");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        txn(0, 16'h0, 1, 0, 16'h0030, 16'h0);

        // LATENCY=1 instance.
        l1_req(0, 1, 0, 16'h0007, 16'h1111, 16'h0);
        l1_req(1, 0, 0, 16'h0007, 16'h0, 16'h1111);
        l1_req(0, 0, 1, 16'h0107, 16'h0, 16'h1111);

        // Fill storage with random words, then random mixed traffic.
        for (int a = 0; a < 256; a++) begin
            txn(0, 16'h0, 0, 1, {8'($urandom), 8'(a)}, 16'($urandom));
        end
        for (int k = 0; k < 300; k++) begin
            ir = 1'($urandom);
            dr = 1'($urandom);
            dw = 1'($urandom);
            if (!ir && !dr && !dw) ir = 1'b1;
            txn(ir, 16'($urandom), dr, dw, 16'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
